oam_dma: RTL and testbench

// - CPU-side writer of primary sprite OAM (256x8) that the sprite evaluator reads.
// - Handles OAMADDR ($2003), OAMDATA ($2004) and the $4014 sprite DMA, which copies CPU page XX00-XXFF into OAM.
// - During DMA the block masters the CPU bus and halts the CPU.

---
 rtl/ppu_pkg.sv | 13 +
 rtl/oam_dma.sv | 119 +++++++++++
 tb/tb_oam_dma.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU constants and the sprite-DMA state encoding used by oam_dma.
package ppu_pkg;

    localparam int          DMA_LEN     = 256;
    localparam logic [15:0] DMA_REG     = 16'h4014;
    localparam int          OAM_AW      = 8;

    localparam logic [2:0]  PPU_OAMADDR = 3'd3;
    localparam logic [2:0]  PPU_OAMDATA = 3'd4;

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// CPU-side OAM writer: OAMADDR/OAMDATA registers plus the $4014 sprite DMA,
// which halts the CPU and copies one 256-byte CPU page into OAM.
module oam_dma
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_ce,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              rendering,
    output logic [15:0]       dma_addr,
    output logic              dma_rd,
    input  logic [7:0]        dma_rdata,
    output logic              cpu_halt,
    output logic [OAM_AW-1:0] oam_addr,
    output logic [7:0]        oam_wdata,
    output logic              oam_we,
    input  logic [7:0]        oam_rdata
);

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [OAM_AW-1:0] r_oamaddr;
    logic [OAM_AW-1:0] r_cnt;
    logic [7:0]        r_page;
    logic [7:0]        r_latch;
    logic              r_parity;

    logic              w_idle;
    logic              w_is_ppu;
    logic              w_reg_wr;
    logic              w_wr_oamaddr;
    logic              w_wr_oamdata;
    logic              w_rd_oamdata;
    logic              w_dma_trig;
    logic              w_dma_wr;
    logic              w_cnt_last;
    logic [OAM_AW-1:0] w_addr_inc;

    // CPU register accesses only count while the DMA engine is idle.
    assign w_idle       = (r_state == IDLE);
    assign w_is_ppu     = (cpu_addr[15:13] == 3'b001);
    assign w_reg_wr     = w_idle && cpu_ce && cpu_we;
    assign w_wr_oamaddr = w_reg_wr && w_is_ppu && (cpu_addr[2:0] == PPU_OAMADDR);
    assign w_wr_oamdata = w_reg_wr && w_is_ppu && (cpu_addr[2:0] == PPU_OAMDATA);
    assign w_rd_oamdata = w_idle && cpu_re && w_is_ppu && (cpu_addr[2:0] == PPU_OAMDATA);
    assign w_dma_trig   = w_reg_wr && (cpu_addr == DMA_REG);
    assign w_dma_wr     = (r_state == WRITE) && cpu_ce;
    assign w_cnt_last   = (r_cnt == OAM_AW'(DMA_LEN - 1));

    // One adder serves OAMDATA writes (+1), rendering-time glitch (+4) and DMA (+1).
    assign w_addr_inc   = r_oamaddr + ((w_wr_oamdata && rendering) ? OAM_AW'(4) : OAM_AW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        if (cpu_ce) begin
            unique case (r_state)
                IDLE:    if (w_dma_trig) w_state_nxt = HALT;
                HALT:    w_state_nxt = r_parity ? ALIGN : READ;
                ALIGN:   w_state_nxt = READ;
                READ:    w_state_nxt = WRITE;
                WRITE:   w_state_nxt = w_cnt_last ? IDLE : READ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_halt  = !w_idle;
        dma_rd    = (r_state == READ);
        dma_addr  = (r_state == READ) ? {r_page, r_cnt} : 16'h0000;
        // NOTE: oam_we is qualified by cpu_ce so it lasts exactly one clk at any clk:cpu_ce ratio.
        oam_we    = w_dma_wr || (w_wr_oamdata && !rendering);
        oam_wdata = (r_state == WRITE) ? r_latch : (w_wr_oamdata ? cpu_wdata : 8'h00);
        oam_addr  = r_oamaddr;
        cpu_rdata = w_rd_oamdata ? oam_rdata : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments only; OAM itself lives outside this block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_oamaddr <= '0;
            r_cnt     <= '0;
            r_page    <= 8'h00;
            r_latch   <= 8'h00;
            r_parity  <= 1'b0;
        end else if (cpu_ce) begin
            r_parity <= !r_parity;
            if (w_wr_oamaddr) begin
                r_oamaddr <= cpu_wdata;
            end else if (w_wr_oamdata || w_dma_wr) begin
                r_oamaddr <= w_addr_inc;
            end
            if (w_dma_trig) begin
                r_page <= cpu_wdata;
                r_cnt  <= '0;
            end else if (w_dma_wr) begin
                r_cnt  <= r_cnt + OAM_AW'(1);
            end
            if (r_state == READ) begin
                r_latch <= dma_rdata;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues expected OAM writes and DMA
// bus addresses; negedge monitors pop and compare whenever the DUT presents them.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        rendering = 1'b0;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_rdata;
    logic        cpu_halt;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] addr_q[$];
    logic [7:0]  oam_mem [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ce_count = 0;
    int          wr_count = 0;
    logic        last_halt = 1'b0;

    always #5 clk = ~clk;

    oam_dma u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .rendering (rendering),
        .dma_addr  (dma_addr),
        .dma_rd    (dma_rd),
        .dma_rdata (dma_rdata),
        .cpu_halt  (cpu_halt),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .oam_rdata (oam_rdata)
    );

    // CPU RAM contents for the pages the DMA tests copy.
    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        case (a[15:8])
            8'h02:   ram_rd = a[7:0] ^ 8'h5A;
            8'h03:   ram_rd = a[7:0] ^ 8'hC3;
            8'hFF:   ram_rd = ~a[7:0];
            default: ram_rd = 8'h00;
        endcase
    endfunction

    assign dma_rdata = dma_rd ? ram_rd(dma_addr) : 8'h00;
    assign oam_rdata = oam_mem[oam_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (oam_we) begin
            if (exp_q.size() == 0) begin
                check("oam_we_not_expected", 32'(oam_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("oam_wr_addr", 32'(oam_addr), 32'(e.addr));
                check("oam_wr_data", 32'(oam_wdata), 32'(e.data));
            end
            oam_mem[oam_addr] = oam_wdata;
            wr_count++;
        end
        if (dma_rd && cpu_ce) begin
            if (addr_q.size() == 0) begin
                check("dma_rd_not_expected", 32'(dma_rd), 32'd0);
            end else begin
                logic [15:0] ea;
                ea = addr_q.pop_front();
                check("dma_addr", 32'(dma_addr), 32'(ea));
            end
        end
    end

    // One CPU cycle: a one-clk cpu_ce pulse followed by two idle clks.
    task automatic cpu_cycle(input logic [15:0] a, input logic we, input logic re, input logic [7:0] d);
        cpu_addr  = a;
        cpu_we    = we;
        cpu_re    = re;
        cpu_wdata = d;
        cpu_ce    = 1'b1;
        last_halt = cpu_halt;
        @(posedge clk);
        #1;
        cpu_ce    = 1'b0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        ce_count++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_dma(input logic [7:0] page, input logic [7:0] start);
        for (int i = 0; i < 256; i++) begin
            wr_t e;
            e.addr = start + 8'(i);
            e.data = ram_rd({page, 8'(i)});
            exp_q.push_back(e);
            addr_q.push_back({page, 8'(i)});
        end
    endtask

    // Parity seen in HALT is that of cpu_ce number ce_count+1 since reset.
    task automatic align_parity(input bit want_odd);
        if (((ce_count + 1) % 2 == 1) != want_odd) cpu_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_dma(input string tag, input logic [7:0] page, input bit want_odd,
                           input bit inject, input logic [7:0] start, input int exp_len);
        int halt_cnt;
        halt_cnt = 0;
        align_parity(want_odd);
        push_dma(page, start);
        cpu_cycle(16'h4014, 1'b1, 1'b0, page);
        check({tag, "_halt_rise"}, 32'(cpu_halt), 32'd1);
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (inject && cyc == 5)      cpu_cycle(16'h4014, 1'b1, 1'b0, 8'h05);
            else if (inject && cyc == 7) cpu_cycle(16'h2003, 1'b1, 1'b0, 8'h33);
            else if (inject && cyc == 9) cpu_cycle(16'h2004, 1'b1, 1'b0, 8'hEE);
            else                         cpu_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
            if (!last_halt) break;
            halt_cnt++;
        end
        check({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(exp_len));
        check({tag, "_halt_low"}, 32'(cpu_halt), 32'd0);
        check({tag, "_dma_rd_low"}, 32'(dma_rd), 32'd0);
        check({tag, "_final_oamaddr"}, 32'(oam_addr), 32'(start));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_reads_left"}, 32'(addr_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_halt", 32'(cpu_halt), 32'd0);
        check("rst_dma_rd", 32'(dma_rd), 32'd0);
        check("rst_dma_addr", 32'(dma_addr), 32'd0);
        check("rst_oam_we", 32'(oam_we), 32'd0);
        check("rst_oam_addr", 32'(oam_addr), 32'd0);
        check("rst_oam_wdata", 32'(oam_wdata), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        reset_n = 1'b1;
        ce_count = 0;
        repeat (2) @(posedge clk);
        #1;

        // OAMADDR/OAMDATA register writes.
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'h10);
        exp_q.push_back('{addr: 8'h10, data: 8'hAA});
        exp_q.push_back('{addr: 8'h11, data: 8'hBB});
        cpu_cycle(16'h2004, 1'b1, 1'b0, 8'hAA);
        cpu_cycle(16'h2004, 1'b1, 1'b0, 8'hBB);
        check("reg_oamaddr_after_writes", 32'(oam_addr), 32'h12);
        check("reg_oam10", 32'(oam_mem[8'h10]), 32'hAA);
        check("reg_oam11", 32'(oam_mem[8'h11]), 32'hBB);

        // $2004 read returns OAM at OAMADDR and leaves OAMADDR alone.
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'h10);
        cpu_addr = 16'h2004;
        cpu_re   = 1'b1;
        #1;
        check("rd_2004_data", 32'(cpu_rdata), 32'hAA);
        cpu_addr = 16'h2002;
        #1;
        check("rd_other_reg_zero", 32'(cpu_rdata), 32'h00);
        cpu_re = 1'b0;
        cpu_cycle(16'h2004, 1'b0, 1'b1, 8'h00);
        check("rd_2004_oamaddr_kept", 32'(oam_addr), 32'h10);

        // Wrap FF -> 00 on a normal write.
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'hFF);
        exp_q.push_back('{addr: 8'hFF, data: 8'h11});
        cpu_cycle(16'h2004, 1'b1, 1'b0, 8'h11);
        check("wrap_oamaddr", 32'(oam_addr), 32'h00);

        // Rendering: no OAM write, OAMADDR += 4 with wrap.
        rendering = 1'b1;
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'hFE);
        cpu_cycle(16'h2004, 1'b1, 1'b0, 8'h77);
        check("render_oamaddr", 32'(oam_addr), 32'h02);
        check("render_oam_fe_kept", 32'(oam_mem[8'hFE]), 32'h00);
        rendering = 1'b0;

        // Even-cycle DMA of page 02 into OAM 00..FF; rendering is ignored by DMA.
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'h00);
        run_dma("even_dma", 8'h02, 1'b0, 1'b0, 8'h00, 513);
        base = 0;
        for (int i = 0; i < 256; i++) if (oam_mem[i] !== (8'(i) ^ 8'h5A)) base++;
        check("even_dma_oam_bad_bytes", 32'(base), 32'd0);

        // Odd-cycle DMA landing at OAM 80, wrapping inside OAM.
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'h80);
        rendering = 1'b1;
        run_dma("odd_dma", 8'h02, 1'b1, 1'b0, 8'h80, 514);
        rendering = 1'b0;
        check("odd_dma_oam80", 32'(oam_mem[8'h80]), 32'h5A);
        check("odd_dma_oam7f", 32'(oam_mem[8'h7F]), 32'hA5);
        check("odd_dma_oam00", 32'(oam_mem[8'h00]), 32'hDA);

        // Reset after 100 DMA writes of page 03.
        cpu_cycle(16'h2003, 1'b1, 1'b0, 8'h00);
        push_dma(8'h03, 8'h00);
        base = wr_count;
        cpu_cycle(16'h4014, 1'b1, 1'b0, 8'h03);
        for (int cyc = 0; cyc < 600 && (wr_count - base) < 100; cyc++) begin
            cpu_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
        end
        check("rstmid_writes_before_reset", 32'(wr_count - base), 32'd100);
        check("rstmid_halt_before", 32'(cpu_halt), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_cpu_halt", 32'(cpu_halt), 32'd0);
        check("rstmid_dma_rd", 32'(dma_rd), 32'd0);
        check("rstmid_oam_we", 32'(oam_we), 32'd0);
        check("rstmid_oam_addr", 32'(oam_addr), 32'h00);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ce_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rstmid_oam00", 32'(oam_mem[8'h00]), 32'hC3);
        check("rstmid_oam63", 32'(oam_mem[8'h63]), 32'hA0);
        check("rstmid_oam64_old", 32'(oam_mem[8'h64]), 32'hBE);
        check("rstmid_oamff_old", 32'(oam_mem[8'hFF]), 32'h25);

        // Page FF DMA with a retrigger, a $2003 and a $2004 write issued mid-transfer.
        run_dma("ign_dma", 8'hFF, 1'b0, 1'b1, 8'h00, 513);
        check("ign_dma_oam00", 32'(oam_mem[8'h00]), 32'hFF);
        check("ign_dma_oamff", 32'(oam_mem[8'hFF]), 32'h00);
        repeat (4) cpu_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
        check("ign_no_restart", 32'(cpu_halt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
